regfile_param: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_if.sv | 32 +++
 rtl/regfile_read_port.sv | 51 +++++
 rtl/regfile_param.sv | 96 +++++++++
 tb/tb_regfile_param.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   rf_state_e : sweep FSM states (RF_CLEAR while zeroing, RF_RUN when usable)
//   RF_DATA_W  : default register width
//   RF_DEPTH   : default register count
//   RF_NUM_RD  : number of read ports built by the top
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 64;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback bus of the register file.
//   RS1, RS2          read addresses (decode)
//   RD, WriteData,
//   RegWrite          write port (writeback)
//   ReadData1/2       registered read data, one cycle after the address
//   Ready             file has finished its clear sweep
// master = pipeline side, slave = register file side.
interface regfile_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] RS1;
    logic [ADDR_W-1:0] RS2;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              Ready;

    modport master (
        output RS1, RS2, RD, WriteData, RegWrite,
        input  ReadData1, ReadData2, Ready
    );

    modport slave (
        input  RS1, RS2, RD, WriteData, RegWrite,
        output ReadData1, ReadData2, Ready
    );
endinterface

// File: rtl/regfile_read_port.sv
// One registered read port of the register file.
//   clk, reset : clock, synchronous active-high reset
//   run        : file is out of its clear sweep; outputs held at 0 otherwise
//   regs       : whole storage array
//   rs         : read address
//   wr_en      : write actually committed this edge (already qualified for
//                run state and the hard-wired zero register)
//   wr_addr    : write address
//   wr_data    : write data
//   rdata      : registered read data
// Build option: REGFILE_BYPASS_EN forwards a same-edge write to this port;
// without it the port returns the old register contents.
module regfile_read_port #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [DEPTH-1:0][DATA_W-1:0] regs,
    input  logic [$clog2(DEPTH)-1:0]     rs,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [DATA_W-1:0]            rdata
);
    localparam int ADDR_W = $clog2(DEPTH);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (!run) begin
            rdata <= '0;
        end else if (BYPASS && wr_en && (wr_addr == rs)) begin
            // wr_en never fires for a dropped register-0 write, so no
            // extra zero check is needed on the forwarding path
            rdata <= wr_data;
        end else if ((ZERO_REG != 0) && (rs == ADDR_W'(0))) begin
            rdata <= '0;
        end else begin
            rdata <= regs[rs];
        end
    end
endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports, one write port.
// After every reset a sweep FSM clears all registers, one per clock; Ready
// rises once the last register has been cleared.
//   clk   : clock
//   reset : synchronous active-high reset, restarts the full sweep
//   bus   : regfile_if slave (read addresses, write port, read data, Ready)
// Parameters: DATA_W, DEPTH (power of two, >= 2), ZERO_REG (1 = register 0
// reads zero and ignores writes). Must match the parameters of bus.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding
// (handled in regfile_read_port).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    rf_state_e                    state, state_nxt;
    logic [ADDR_W-1:0]            cnt;
    logic                         clr_en;
    logic                         run;
    logic                         wr_en;
    logic [DEPTH-1:0][DATA_W-1:0] regs;

    logic [RF_NUM_RD-1:0][ADDR_W-1:0] rs_vec;
    logic [RF_NUM_RD-1:0][DATA_W-1:0] rdata_vec;

    // FSM state and sweep counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (clr_en) cnt <= cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        clr_en    = 1'b0;
        case (state)
            RF_CLEAR: begin
                clr_en = 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = RF_RUN;
            end
            RF_RUN:   state_nxt = RF_RUN;
            default:  state_nxt = RF_CLEAR;
        endcase
    end

    assign run = (state == RF_RUN);

    // Committed write: only in RUN, never on a reset edge, and dropped for
    // the hard-wired zero register
    assign wr_en = run && !reset && bus.RegWrite &&
                   !((ZERO_REG != 0) && (bus.RD == ADDR_W'(0)));

    // Storage: no reset; the sweep zeroes it after every reset instead
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en)     regs[cnt]    <= '0;
            else if (wr_en) regs[bus.RD] <= bus.WriteData;
        end
    end

    assign rs_vec = {bus.RS2, bus.RS1};

    for (genvar p = 0; p < RF_NUM_RD; p++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .clk     (clk),
            .reset   (reset),
            .run     (run),
            .regs    (regs),
            .rs      (rs_vec[p]),
            .wr_en   (wr_en),
            .wr_addr (bus.RD),
            .wr_data (bus.WriteData),
            .rdata   (rdata_vec[p])
        );
    end

    assign bus.ReadData1 = rdata_vec[0];
    assign bus.ReadData2 = rdata_vec[1];
    assign bus.Ready     = run;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: a 64x32 file with ZERO_REG=1 and a 32x8 file with
// ZERO_REG=0 see the same stimulus; a reference model tracks each and a
// negedge process compares every output, plus directed literal checks.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;

    regfile_if #(.DATA_W(64), .DEPTH(32)) a ();
    regfile_if #(.DATA_W(32), .DEPTH(8))  b ();

    regfile_param #(.DATA_W(64), .DEPTH(32), .ZERO_REG(1)) dut0 (
        .clk(clk), .reset(reset), .bus(a.slave)
    );
    regfile_param #(.DATA_W(32), .DEPTH(8), .ZERO_REG(0)) dut1 (
        .clk(clk), .reset(reset), .bus(b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus as seen by the model (full width; model masks per instance)
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [63:0] s_wd;
    logic        s_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [63:0] wd, input logic we);
        s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_wd = wd; s_we = we;
        a.RS1 = rs1; a.RS2 = rs2; a.RD = rd; a.WriteData = wd; a.RegWrite = we;
        b.RS1 = rs1[2:0]; b.RS2 = rs2[2:0]; b.RD = rd[2:0];
        b.WriteData = wd[31:0]; b.RegWrite = we;
    endtask

    // ---------------- reference model ----------------
    // m=0: 64-bit, 32 regs, register 0 hard-wired; m=1: 32-bit, 8 regs, plain
    logic [63:0] mem [2][32];
    int          clear_left [2];
    logic [63:0] e1 [2];
    logic [63:0] e2 [2];
    bit          known [2];

    function automatic logic [63:0] model_read(input int m, input int rs, input bit zr,
                                               input bit wr, input int wa, input logic [63:0] wdat);
        if (BYP && wr && wa == rs) return wdat;
        if (zr && rs == 0) return 64'd0;
        return mem[m][rs];
    endfunction

    initial begin
        known[0] = 1'b0; known[1] = 1'b0;
        clear_left[0] = 0; clear_left[1] = 0;
    end

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int          d, r1, r2, wa;
            bit          zr, wr;
            logic [63:0] dm, wdat;
            d    = (m == 0) ? 32 : 8;
            zr   = (m == 0);
            dm   = (m == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
            r1   = int'(s_rs1) % d;
            r2   = int'(s_rs2) % d;
            wa   = int'(s_rd) % d;
            wdat = s_wd & dm;
            if (reset) begin
                clear_left[m] = d;
                e1[m] = 64'd0; e2[m] = 64'd0;
                known[m] = 1'b1;
            end else if (clear_left[m] > 0) begin
                mem[m][d - clear_left[m]] = 64'd0;
                clear_left[m] = clear_left[m] - 1;
                e1[m] = 64'd0; e2[m] = 64'd0;
            end else begin
                wr = s_we && !(zr && wa == 0);
                e1[m] = model_read(m, r1, zr, wr, wa, wdat);
                e2[m] = model_read(m, r2, zr, wr, wa, wdat);
                if (wr) mem[m][wa] = wdat;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (known[0]) begin
            chk("a_ready", {63'd0, a.Ready}, {63'd0, clear_left[0] == 0});
            chk("a_rd1", a.ReadData1, e1[0]);
            chk("a_rd2", a.ReadData2, e2[0]);
        end
        if (known[1]) begin
            chk("b_ready", {63'd0, b.Ready}, {63'd0, clear_left[1] == 0});
            chk("b_rd1", {32'd0, b.ReadData1}, e1[1]);
            chk("b_rd2", {32'd0, b.ReadData2}, e2[1]);
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [63:0] hz;
        reset = 1'b1;
        drive(0, 0, 0, 64'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // attempt a write during the sweep; it must be ignored
        drive(0, 0, 3, 64'h77, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 6) drive(0, 0, 0, 64'd0, 1'b0);
            if (i == 1) chk("clear_rd1_zero", a.ReadData1, 64'd0);
            if (i == 7) chk("b_ready_7", {63'd0, b.Ready}, 64'd0);
            if (i == 8) chk("b_ready_8", {63'd0, b.Ready}, 64'd1);
            if (i == 31) chk("a_ready_31", {63'd0, a.Ready}, 64'd0);
            if (i == 32) chk("a_ready_32", {63'd0, a.Ready}, 64'd1);
        end
        drive(3, 3, 0, 64'd0, 1'b0);
        @(negedge clk);
        chk("clear_write_ignored_a", a.ReadData1, 64'd0);
        chk("clear_write_ignored_b", {32'd0, b.ReadData1}, 64'd0);

        // basic write/read
        drive(0, 0, 5, 64'd110, 1'b1);
        @(negedge clk);
        drive(5, 0, 0, 64'd0, 1'b0);
        @(negedge clk);
        chk("basic_rd1", a.ReadData1, 64'd110);
        chk("basic_rd2", a.ReadData2, 64'd0);

        // zero register
        drive(0, 0, 0, 64'hDEAD, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, 64'd0, 1'b0);
        @(negedge clk);
        chk("zero_reg_on", a.ReadData1, 64'd0);
        chk("zero_reg_off", {32'd0, b.ReadData1}, 64'hDEAD);

        // same-edge hazard
        drive(0, 0, 7, 64'd1000, 1'b1);
        @(negedge clk);
        drive(7, 7, 7, 64'd9000, 1'b1);
        @(negedge clk);
        hz = BYP ? 64'd9000 : 64'd1000;
        chk("hazard_rd1", a.ReadData1, hz);
        chk("hazard_rd2", a.ReadData2, hz);
        drive(7, 7, 0, 64'd0, 1'b0);
        @(negedge clk);
        chk("hazard_next_rd1", a.ReadData1, 64'd9000);
        chk("hazard_next_rd2", a.ReadData2, 64'd9000);

        // narrow instance, all-ones data
        drive(0, 0, 7, 64'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        drive(0, 7, 0, 64'd0, 1'b0);
        @(negedge clk);
        chk("narrow_ones", {32'd0, b.ReadData2}, 64'hFFFF_FFFF);

        // random traffic (also leaves garbage in the array)
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom),
                  {$urandom, $urandom}, 1'($urandom));
            @(negedge clk);
        end

        // reset, then reassert mid-sweep at cycle 10
        drive(0, 0, 0, 64'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 22) chk("restart_ready_22", {63'd0, a.Ready}, 64'd0);
            if (i == 32) chk("restart_ready_32", {63'd0, a.Ready}, 64'd1);
        end
        // every register swept to zero
        for (int i = 0; i < 32; i++) begin
            drive(5'(i), 5'(31 - i), 0, 64'd0, 1'b0);
            @(negedge clk);
            chk("swept_a", a.ReadData1, 64'd0);
            chk("swept_b", {32'd0, b.ReadData2}, 64'd0);
        end

        // more random traffic after the second sweep
        for (int i = 0; i < 200; i++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom),
                  {$urandom, $urandom}, 1'($urandom));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
